timer_apb_ctrl: RTL and testbench
=================================

Name: timer_apb_ctrl

Overview:
- APB-slave register/control front end of the 8-bit timer.
- Holds TDR (reload data), TCR (control) and TSR (status).
- Reads back the live counter value TCNT from the external counter core.
- Drives the counter core's load, enable, direction, start value and prescaled count-tick.
- Latches sticky overflow/underflow flags from the counter core's one-cycle pulses.

Parameters:
- ADDR_WIDTH, 8, APB address width.
- DATA_WIDTH, 8, register/data width.

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  synchronous active-high reset.
- PSEL  in  1  APB select.
- PWRITE  in  1  APB write (1) / read (0).
- PENABLE  in  1  APB access phase.
- PADDR  in  ADDR_WIDTH  APB address.
- PWDATA  in  DATA_WIDTH  APB write data.
- PRDATA  out  DATA_WIDTH  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- TCNT_Out  in  DATA_WIDTH  current counter value from counter core.
- Set_OVF_pulse  in  1  one-cycle overflow event.
- Set_UDF_pulse  in  1  one-cycle underflow event.
- Load_Tdr  out  1  counter load request.
- count_start_value  out  DATA_WIDTH  value to load (= TDR).
- count_up_down  out  1  0 = up, 1 = down.
- count_enable  out  1  counting permitted.
- Clock_counter  out  1  one-PCLK-wide count tick.

Behaviour:
- Reset: TDR, TCR, TSR, prescaler, PRDATA, PSLVERR all 0; outputs derived from them are 0.
- Register map (offsets):
  - 0x00 TDR, RW.
  - 0x01 TCR, RW; only bits 7, 5, 4, 1:0 are writable, other bits read 0.
  - 0x02 TSR, bit0 OVF, bit1 UDF, W1C, other bits read 0.
  - 0x03 TCNT, RO; returns TCNT_Out.
- TCR fields: bit7 LOAD, bit5 UP_DW (1 = down), bit4 EN, bits1:0 CKS.
- Access: a transfer completes in the cycle where PSEL & PENABLE & PREADY = 1.
  - Write: register updates at that edge.
  - Read: PRDATA is registered, valid from the following edge, and held until the next read completes.
- PREADY is constant 1 (no wait states) unless the optional feature is enabled.
- PSLVERR:
  - Registered with the same timing as PRDATA, cleared by the next completed transfer.
  - Set to 1 for an address > 0x03, or a write to 0x03.
  - On an errored transfer no register changes and PRDATA is 0x00.
- TSR flags:
  - Bit set to 1 on its pulse.
  - Cleared by writing 1 to that bit; writing 0 has no effect.
  - Pulse and clear in the same cycle: set wins.
  - Flags are only set by the pulses; loads never touch them.
- Control outputs, all combinational from registers:
  - Load_Tdr = TCR[7], level.
  - count_start_value = TDR.
  - count_up_down = TCR[5].
  - count_enable = TCR[4] & ~TCR[7], so load has priority over counting.
- Prescaler (select_clock function):
  - 4-bit free-running counter on PCLK, cleared by reset.
  - Clock_counter = 1 for one cycle when the low (CKS+1) bits are all ones.
  - Tick period: CKS 00 → /2, 01 → /4, 10 → /8, 11 → /16.
  - Ticks are generated regardless of EN.
  - A CKS change takes effect on the next cycle; the prescaler is not reset.
- Reset mid-transfer: the transfer is aborted and all state returns to reset values.

Optional Feature:
- Macro TIMER_WAIT_STATE_EN.
- Defined: one wait state per access.
  - PREADY = 0 in the first access-phase cycle (PSEL & PENABLE) and 1 in the second.
  - A completion flag clears when PSEL drops.
- Undefined: PREADY tied to 1.

Decomposition:
- Package timer_pkg holds:
  - Register offsets TDR_ADDR 0x00, TCR_ADDR 0x01, TSR_ADDR 0x02, TCNT_ADDR 0x03.
  - TCR bit positions LOAD=7, UP_DW=5, EN=4, CKS=1:0.
  - TSR bit positions OVF=0, UDF=1.
- One sub-module: timer_prescaler (CKS in, Clock_counter out).
- Register file and control decode stay in the top.

Test Plan:
- Reset, then read all four addresses → 0x00 each, PSLVERR = 0.
- Write TDR = 0x5A and TCR = 0xB3, read back → TDR 0x5A, TCR 0xB3; reserved bits masked, so writing 0xFF to TCR reads 0xB3. Load_Tdr = 1, count_enable = 0, count_up_down = 1, count_start_value = 0x5A.
- Load/no-count: TCR = EN=0, LOAD toggled with TDR 0x00 then 0xFF, no pulses driven → TSR reads 0x00.
- Flags: drive Set_OVF_pulse for one cycle → TSR = 0x01; write TSR 0x01 → 0x00. Same for UDF → 0x02. Pulse coincident with the clear → flag stays 1.
- CKS 00/01/10/11 with EN=0 → Clock_counter period 2/4/8/16 PCLK, each tick one cycle wide.
- Write 0x5A to address 0xAA, and write to 0x03 → PSLVERR = 1, no register changes. With TIMER_WAIT_STATE_EN, the first access cycle has PREADY = 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer APB front end: register offsets,
// register field positions and the prescaler tick mask helper.
package timer_pkg;

    localparam logic [7:0] TDR_ADDR  = 8'h00;
    localparam logic [7:0] TCR_ADDR  = 8'h01;
    localparam logic [7:0] TSR_ADDR  = 8'h02;
    localparam logic [7:0] TCNT_ADDR = 8'h03;

    localparam int unsigned TCR_LOAD   = 7;
    localparam int unsigned TCR_UP_DW  = 5;
    localparam int unsigned TCR_EN     = 4;
    localparam int unsigned TCR_CKS_HI = 1;
    localparam int unsigned TCR_CKS_LO = 0;

    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

    // Writable TCR bits: LOAD, UP_DW, EN, CKS[1:0]
    localparam logic [7:0] TCR_WMASK = 8'hB3;

    typedef enum logic [1:0] {
        SEL_TDR,
        SEL_TCR,
        SEL_TSR,
        SEL_TCNT
    } reg_sel_e;

    function automatic logic [3:0] cks_mask(input logic [1:0] cks);
        case (cks)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 4-bit prescaler; emits a one-PCLK count tick every 2/4/8/16
// cycles depending on CKS.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [1:0] CKS,
    output logic       Clock_counter
);

    logic [3:0] div_cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    always_comb begin
        Clock_counter = ((div_cnt & cks_mask(CKS)) == cks_mask(CKS));
    end

endmodule

// File: rtl/timer_apb_ctrl.sv
// APB register/control front end of the 8-bit timer (TDR, TCR, TSR, TCNT).
// Define TIMER_WAIT_STATE_EN to insert one wait state per APB access.
module timer_apb_ctrl
    import timer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PWRITE,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] TCNT_Out,
    input  logic                  Set_OVF_pulse,
    input  logic                  Set_UDF_pulse,
    output logic                  Load_Tdr,
    output logic [DATA_WIDTH-1:0] count_start_value,
    output logic                  count_up_down,
    output logic                  count_enable,
    output logic                  Clock_counter
);

    logic [DATA_WIDTH-1:0] tdr;
    logic [DATA_WIDTH-1:0] tcr;
    logic [1:0]            tsr_flags;
    reg_sel_e              sel;
    logic                  addr_ok;
    logic                  xfer_err;
    logic                  xfer;
    logic                  wr_ok;
    logic [1:0]            tsr_clr;
    logic [DATA_WIDTH-1:0] rd_data;

`ifdef TIMER_WAIT_STATE_EN
    logic ws_done;

    // Set in the first access cycle, cleared on completion or when PSEL drops
    always_ff @(posedge PCLK) begin
        if (PRESET || !PSEL) begin
            ws_done <= 1'b0;
        end else if (PENABLE) begin
            ws_done <= !ws_done;
        end
    end

    assign PREADY = ws_done;
`else
    assign PREADY = 1'b1;
`endif

    assign xfer = PSEL & PENABLE & PREADY;

    always_comb begin
        sel     = SEL_TDR;
        addr_ok = 1'b1;
        case (PADDR)
            ADDR_WIDTH'(TDR_ADDR):  sel = SEL_TDR;
            ADDR_WIDTH'(TCR_ADDR):  sel = SEL_TCR;
            ADDR_WIDTH'(TSR_ADDR):  sel = SEL_TSR;
            ADDR_WIDTH'(TCNT_ADDR): sel = SEL_TCNT;
            default:                addr_ok = 1'b0;
        endcase
    end

    assign xfer_err = !addr_ok || (PWRITE && (sel == SEL_TCNT));
    assign wr_ok    = xfer && PWRITE && !xfer_err;
    assign tsr_clr  = (wr_ok && (sel == SEL_TSR)) ? {PWDATA[TSR_UDF], PWDATA[TSR_OVF]} : 2'b00;

    always_comb begin
        rd_data = '0;
        case (sel)
            SEL_TDR:  rd_data = tdr;
            SEL_TCR:  rd_data = tcr;
            SEL_TSR:  rd_data = DATA_WIDTH'(tsr_flags);
            SEL_TCNT: rd_data = TCNT_Out;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tdr       <= '0;
            tcr       <= '0;
            tsr_flags <= '0;
            PRDATA    <= '0;
            PSLVERR   <= 1'b0;
        end else begin
            if (wr_ok && (sel == SEL_TDR)) begin
                tdr <= PWDATA;
            end
            if (wr_ok && (sel == SEL_TCR)) begin
                tcr <= PWDATA & DATA_WIDTH'(TCR_WMASK);
            end
            // Pulse applied after the clear so a coincident event wins
            tsr_flags <= (tsr_flags & ~tsr_clr) | {Set_UDF_pulse, Set_OVF_pulse};
            if (xfer) begin
                PSLVERR <= xfer_err;
                if (xfer_err) begin
                    PRDATA <= '0;
                end else if (!PWRITE) begin
                    PRDATA <= rd_data;
                end
            end
        end
    end

    assign Load_Tdr          = tcr[TCR_LOAD];
    assign count_start_value = tdr;
    assign count_up_down     = tcr[TCR_UP_DW];
    assign count_enable      = tcr[TCR_EN] & ~tcr[TCR_LOAD];

    timer_prescaler u_prescaler (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .CKS           (tcr[TCR_CKS_HI:TCR_CKS_LO]),
        .Clock_counter (Clock_counter)
    );

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Self-checking bench for timer_apb_ctrl against a register-level model of
// the timer front end; honours TIMER_WAIT_STATE_EN when defined.
module tb_timer_apb_ctrl;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       PSEL = 1'b0;
    logic       PWRITE = 1'b0;
    logic       PENABLE = 1'b0;
    logic [7:0] PADDR = '0;
    logic [7:0] PWDATA = '0;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [7:0] TCNT_Out = '0;
    logic       Set_OVF_pulse = 1'b0;
    logic       Set_UDF_pulse = 1'b0;
    logic       Load_Tdr;
    logic [7:0] count_start_value;
    logic       count_up_down;
    logic       count_enable;
    logic       Clock_counter;

`ifdef TIMER_WAIT_STATE_EN
    localparam logic EXP_RDY_FIRST = 1'b0;
`else
    localparam logic EXP_RDY_FIRST = 1'b1;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    logic [7:0] tdr_m, tcr_m;
    logic [1:0] tsr_m;

    timer_apb_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .PCLK              (PCLK),
        .PRESET            (PRESET),
        .PSEL              (PSEL),
        .PWRITE            (PWRITE),
        .PENABLE           (PENABLE),
        .PADDR             (PADDR),
        .PWDATA            (PWDATA),
        .PRDATA            (PRDATA),
        .PREADY            (PREADY),
        .PSLVERR           (PSLVERR),
        .TCNT_Out          (TCNT_Out),
        .Set_OVF_pulse     (Set_OVF_pulse),
        .Set_UDF_pulse     (Set_UDF_pulse),
        .Load_Tdr          (Load_Tdr),
        .count_start_value (count_start_value),
        .count_up_down     (count_up_down),
        .count_enable      (count_enable),
        .Clock_counter     (Clock_counter)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [1:0] pulse, output logic [7:0] rd, output logic e);
        int n;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = w; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        {Set_UDF_pulse, Set_OVF_pulse} = pulse;
        @(negedge PCLK);
        check("pready_first", PREADY, EXP_RDY_FIRST);
        n = 0;
        while (PREADY !== 1'b1 && n < 4) begin
            @(negedge PCLK);
            n++;
        end
        check("pready_bound", PREADY, 1'b1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        {Set_UDF_pulse, Set_OVF_pulse} = 2'b00;
        @(negedge PCLK);
        rd = PRDATA;
        e  = PSLVERR;
    endtask

    function automatic logic exp_err(input logic w, input logic [7:0] a);
        return (a > 8'h03) || (w && a == 8'h03);
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [1:0] pulse);
        logic [7:0] rd;
        logic e;
        logic ee;
        ee = exp_err(1'b1, a);
        apb(1'b1, a, d, pulse, rd, e);
        check("wr_pslverr", e, ee);
        if (ee) check("wr_err_prdata", rd, 8'h00);
        if (!ee) begin
            case (a)
                8'h00: tdr_m = d;
                8'h01: tcr_m = d & 8'hB3;
                8'h02: tsr_m = tsr_m & ~d[1:0];
                default: ;
            endcase
        end
        tsr_m = tsr_m | pulse;
    endtask

    task automatic do_read(input logic [7:0] a, input string tag);
        logic [7:0] rd;
        logic [7:0] exp;
        logic e;
        logic ee;
        ee = exp_err(1'b0, a);
        case (a)
            8'h00:   exp = tdr_m;
            8'h01:   exp = tcr_m;
            8'h02:   exp = {6'b0, tsr_m};
            8'h03:   exp = TCNT_Out;
            default: exp = 8'h00;
        endcase
        apb(1'b0, a, 8'h00, 2'b00, rd, e);
        check({tag, "_data"}, rd, exp);
        check({tag, "_pslverr"}, e, ee);
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_load"},  Load_Tdr, tcr_m[7]);
        check({tag, "_en"},    count_enable, tcr_m[4] && !tcr_m[7]);
        check({tag, "_updw"},  count_up_down, tcr_m[5]);
        check({tag, "_start"}, count_start_value, tdr_m);
    endtask

    task automatic pulse_flag(input logic [1:0] which);
        @(posedge PCLK); #1;
        {Set_UDF_pulse, Set_OVF_pulse} = which;
        @(posedge PCLK); #1;
        {Set_UDF_pulse, Set_OVF_pulse} = 2'b00;
        tsr_m = tsr_m | which;
    endtask

    // Ticks must recur exactly every p cycles once the first one is seen
    task automatic measure_ticks(input int p);
        int f;
        f = -1;
        for (int i = 0; i < 48; i++) begin
            @(negedge PCLK);
            if (f < 0) begin
                if (Clock_counter === 1'b1) f = i;
            end else begin
                check($sformatf("tick_p%0d", p), Clock_counter, ((i - f) % p) == 0);
            end
        end
        check($sformatf("first_tick_p%0d", p), (f >= 0) && (f < p), 1'b1);
    endtask

    initial begin
        logic [7:0] a, d;
        tdr_m = '0; tcr_m = '0; tsr_m = '0;

        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_prdata", PRDATA, 8'h00);
        check("rst_pslverr", PSLVERR, 1'b0);
        check_outs("rst");
        for (int i = 0; i < 4; i++) do_read(8'(i), "rst_read");

        do_write(8'h00, 8'h5A, 2'b00);
        do_write(8'h01, 8'hB3, 2'b00);
        do_read(8'h00, "tdr_5a");
        do_read(8'h01, "tcr_b3");
        check_outs("tcr_b3");
        do_write(8'h01, 8'hFF, 2'b00);
        do_read(8'h01, "tcr_mask");
        check_outs("tcr_ff");

        do_write(8'h01, 8'h00, 2'b00);
        do_write(8'h00, 8'h00, 2'b00);
        do_write(8'h01, 8'h80, 2'b00);
        check_outs("load0");
        do_write(8'h01, 8'h00, 2'b00);
        do_write(8'h00, 8'hFF, 2'b00);
        do_write(8'h01, 8'h80, 2'b00);
        check_outs("loadff");
        do_read(8'h02, "tsr_noflags");

        pulse_flag(2'b01);
        do_read(8'h02, "tsr_ovf");
        do_write(8'h02, 8'h00, 2'b00);
        do_read(8'h02, "tsr_w0");
        do_write(8'h02, 8'h01, 2'b00);
        do_read(8'h02, "tsr_ovf_clr");
        pulse_flag(2'b10);
        do_read(8'h02, "tsr_udf");
        do_write(8'h02, 8'h02, 2'b00);
        do_read(8'h02, "tsr_udf_clr");
        pulse_flag(2'b11);
        do_write(8'h02, 8'h03, 2'b01);
        do_read(8'h02, "tsr_set_wins");
        do_write(8'h02, 8'h03, 2'b00);
        do_read(8'h02, "tsr_all_clr");

        for (int c = 0; c < 4; c++) begin
            do_write(8'h01, 8'(c), 2'b00);
            measure_ticks(2 << c);
        end

        do_write(8'h00, 8'h3C, 2'b00);
        do_write(8'hAA, 8'h5A, 2'b00);
        do_read(8'h00, "err_tdr_kept");
        do_write(8'h03, 8'h77, 2'b00);
        do_read(8'hAA, "err_rd");
        do_read(8'h00, "err_cleared");

        for (int k = 0; k < 24; k++) begin
            a = 8'($urandom_range(0, 2));
            d = 8'($urandom);
            do_write(a, d, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) do_write(8'($urandom_range(4, 255)), 8'($urandom), 2'b00);
            TCNT_Out = 8'($urandom);
            do_read(a, "rnd_rb");
            do_read(8'h03, "rnd_tcnt");
            check_outs("rnd");
        end

        do_write(8'h01, 8'hB1, 2'b00);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h77; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        tdr_m = '0; tcr_m = '0; tsr_m = '0;
        @(negedge PCLK);
        check("midrst_prdata", PRDATA, 8'h00);
        check_outs("midrst");
        do_read(8'h00, "midrst_tdr");
        do_read(8'h01, "midrst_tcr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
